shift_result_fifo: RTL and testbench

//  Buffer stage directly downstream of the registered shift unit.

---
 rtl/shift_result_fifo.sv | 97 +++++++++
 tb/tb_shift_result_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_result_fifo.sv
// First-word-fall-through result buffer behind the registered shift unit.
// Full-FIFO writes are dropped and tallied in a sticky flag and a saturating counter.
module shift_result_fifo #(
  parameter int unsigned data_width = 16,
  parameter int unsigned depth      = 4,
  parameter int unsigned addr_width = 2,
  parameter int unsigned cnt_width  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [addr_width:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic [cnt_width-1:0]  drop_cnt
);

  localparam logic [addr_width:0] full_count = (addr_width+1)'(depth);

  logic [data_width-1:0] mem [depth];
  logic [addr_width-1:0] wr_ptr_q;
  logic [addr_width-1:0] rd_ptr_q;
  logic [addr_width:0]   count_q;
  logic                  overflow_q;
  logic [cnt_width-1:0]  drop_cnt_q;

  logic pop;
  logic push;
  logic drop;

  always_comb begin
    full      = (count_q == full_count);
    empty     = (count_q == '0);
    out_valid = ~empty;
    pop       = out_valid & out_ready;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    push      = in_valid & (~full | pop);
    drop      = in_valid & full & ~pop;
  end

  // Storage is deliberately not reset; out_data is masked while empty.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + addr_width'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + addr_width'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (addr_width+1)'(1);
        2'b01:   count_q <= count_q - (addr_width+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A drop in the same cycle as clr_ovf wins: the flag stays set, counter restarts at 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clr_ovf) begin
        drop_cnt_q <= cnt_width'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_q <= drop_cnt_q + cnt_width'(1);
      end
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign out_data = out_valid ? mem[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_shift_result_fifo.sv
// Directed bench for shift_result_fifo: a vector table for the main traffic
// plus hand sequences for reset, counter saturation and mid-operation reset.
module tb_shift_result_fifo;

  logic        CLK;
  logic        RST;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clr_ovf;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  shift_result_fifo #(
    .data_width(16),
    .depth     (4),
    .addr_width(2),
    .cnt_width (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .drop_cnt (drop_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        c;
    logic [2:0]  cnt;
    logic        ov;
    logic [15:0] od;
    logic        fl;
    logic        ovf;
    logic [7:0]  dc;
  } vec_t;

  localparam int NumVec = 26;
  vec_t vecs [NumVec];

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic r,
                              input logic c, input logic [2:0] cnt, input logic ov,
                              input logic [15:0] od, input logic fl, input logic ovf,
                              input logic [7:0] dc);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.c = c; t.cnt = cnt; t.ov = ov;
    t.od = od; t.fl = fl; t.ovf = ovf; t.dc = dc;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [2:0] e_cnt,
                           input logic e_ov, input logic [15:0] e_od, input logic e_fl,
                           input logic e_ovf, input logic [7:0] e_dc);
    check({tag, ".count"}, idx, 32'(count), 32'(e_cnt));
    check({tag, ".out_valid"}, idx, 32'(out_valid), 32'(e_ov));
    check({tag, ".out_data"}, idx, 32'(out_data), 32'(e_od));
    check({tag, ".full"}, idx, 32'(full), 32'(e_fl));
    check({tag, ".empty"}, idx, 32'(empty), 32'(e_cnt == 3'd0));
    check({tag, ".overflow"}, idx, 32'(overflow), 32'(e_ovf));
    check({tag, ".drop_cnt"}, idx, 32'(drop_cnt), 32'(e_dc));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at that point.
  task automatic step(input logic v, input logic [15:0] d, input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr_ovf   = c;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //               v     d         r     c     cnt   ov    od        fl    ovf   dc
    // Two words held, then drained.
    vecs[0]  = mk(1'b1, 16'h0001, 1'b0, 1'b0, 3'd1, 1'b1, 16'h0001, 1'b0, 1'b0, 8'd0);
    vecs[1]  = mk(1'b1, 16'h0002, 1'b0, 1'b0, 3'd2, 1'b1, 16'h0001, 1'b0, 1'b0, 8'd0);
    vecs[2]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 3'd2, 1'b1, 16'h0001, 1'b0, 1'b0, 8'd0);
    vecs[3]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b1, 16'h0002, 1'b0, 1'b0, 8'd0);
    vecs[4]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);
    // Five pushes into depth 4: the fifth is dropped.
    vecs[5]  = mk(1'b1, 16'h00a1, 1'b0, 1'b0, 3'd1, 1'b1, 16'h00a1, 1'b0, 1'b0, 8'd0);
    vecs[6]  = mk(1'b1, 16'h00a2, 1'b0, 1'b0, 3'd2, 1'b1, 16'h00a1, 1'b0, 1'b0, 8'd0);
    vecs[7]  = mk(1'b1, 16'h00a3, 1'b0, 1'b0, 3'd3, 1'b1, 16'h00a1, 1'b0, 1'b0, 8'd0);
    vecs[8]  = mk(1'b1, 16'h00a4, 1'b0, 1'b0, 3'd4, 1'b1, 16'h00a1, 1'b1, 1'b0, 8'd0);
    vecs[9]  = mk(1'b1, 16'h00a5, 1'b0, 1'b0, 3'd4, 1'b1, 16'h00a1, 1'b1, 1'b1, 8'd1);
    // Full FIFO streaming: push and pop together across pointer wrap.
    vecs[10] = mk(1'b1, 16'h00b1, 1'b1, 1'b0, 3'd4, 1'b1, 16'h00a2, 1'b1, 1'b1, 8'd1);
    vecs[11] = mk(1'b1, 16'h00b2, 1'b1, 1'b0, 3'd4, 1'b1, 16'h00a3, 1'b1, 1'b1, 8'd1);
    vecs[12] = mk(1'b1, 16'h00b3, 1'b1, 1'b0, 3'd4, 1'b1, 16'h00a4, 1'b1, 1'b1, 8'd1);
    vecs[13] = mk(1'b1, 16'h00b4, 1'b1, 1'b0, 3'd4, 1'b1, 16'h00b1, 1'b1, 1'b1, 8'd1);
    vecs[14] = mk(1'b1, 16'h00b5, 1'b1, 1'b0, 3'd4, 1'b1, 16'h00b2, 1'b1, 1'b1, 8'd1);
    vecs[15] = mk(1'b1, 16'h00b6, 1'b1, 1'b0, 3'd4, 1'b1, 16'h00b3, 1'b1, 1'b1, 8'd1);
    // Second drop, then drop with clear (set wins), then clear alone.
    vecs[16] = mk(1'b1, 16'h00c0, 1'b0, 1'b0, 3'd4, 1'b1, 16'h00b3, 1'b1, 1'b1, 8'd2);
    vecs[17] = mk(1'b1, 16'h00c1, 1'b0, 1'b1, 3'd4, 1'b1, 16'h00b3, 1'b1, 1'b1, 8'd1);
    vecs[18] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 1'b1, 16'h00b3, 1'b1, 1'b0, 8'd0);
    // Drain in order.
    vecs[19] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 1'b1, 16'h00b4, 1'b0, 1'b0, 8'd0);
    vecs[20] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 3'd2, 1'b1, 16'h00b5, 1'b0, 1'b0, 8'd0);
    vecs[21] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b1, 16'h00b6, 1'b0, 1'b0, 8'd0);
    vecs[22] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);
    // Push with ready on an empty FIFO: no pop that cycle; then one-deep streaming.
    vecs[23] = mk(1'b1, 16'h00d1, 1'b1, 1'b0, 3'd1, 1'b1, 16'h00d1, 1'b0, 1'b0, 8'd0);
    vecs[24] = mk(1'b1, 16'h00d2, 1'b1, 1'b0, 3'd1, 1'b1, 16'h00d2, 1'b0, 1'b0, 8'd0);
    vecs[25] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);

    RST       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_all("reset", 0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check_all("idle", 0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < NumVec; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
      check_all("vec", i, vecs[i].cnt, vecs[i].ov, vecs[i].od, vecs[i].fl, vecs[i].ovf,
                vecs[i].dc);
    end

    // Drop counter saturation.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'h00f0 + 16'(i), 1'b0, 1'b0);
    end
    check_all("fill", 0, 3'd4, 1'b1, 16'h00f0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 255; i++) begin
      step(1'b1, 16'hdead, 1'b0, 1'b0);
    end
    check_all("sat255", 0, 3'd4, 1'b1, 16'h00f0, 1'b1, 1'b1, 8'hff);
    for (int i = 0; i < 45; i++) begin
      step(1'b1, 16'hbeef, 1'b0, 1'b0);
    end
    check_all("sat300", 0, 3'd4, 1'b1, 16'h00f0, 1'b1, 1'b1, 8'hff);

    // Reset mid-operation with count=3 and a push pending.
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_all("pre_rst", 0, 3'd3, 1'b1, 16'h00f1, 1'b0, 1'b1, 8'hff);
    RST = 1'b1;
    step(1'b1, 16'h00ee, 1'b0, 1'b1);
    RST = 1'b0;
    check_all("mid_rst", 0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);
    step(1'b1, 16'h00e1, 1'b0, 1'b0);
    check_all("post_rst", 0, 3'd1, 1'b1, 16'h00e1, 1'b0, 1'b0, 8'd0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_all("post_rst_pop", 0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
